// File: rtl/zhiwen_pkg.sv
// Shared constants for the fingerprint sensor link: packet framing bytes,
// instruction codes, host command encodings and the command payload table.
package zhiwen_pkg;

    localparam logic [7:0] HDR_0   = 8'hEF;
    localparam logic [7:0] HDR_1   = 8'h01;
    localparam logic [7:0] PID_CMD = 8'h01;

    localparam logic [7:0] GET_IMAGE = 8'h01;
    localparam logic [7:0] GEN_CHAR  = 8'h02;
    localparam logic [7:0] SEARCH    = 8'h04;

    localparam logic [7:0] BUF_1 = 8'h01;
    localparam logic [7:0] BUF_2 = 8'h02;

    localparam logic [15:0] SEARCH_START = 16'd0;
    localparam logic [15:0] SEARCH_COUNT = 16'd200;

    typedef enum logic [1:0] {
        CMD_GET_IMAGE = 2'd0,
        CMD_GEN_CHAR1 = 2'd1,
        CMD_GEN_CHAR2 = 2'd2,
        CMD_SEARCH    = 2'd3
    } cmd_sel_e;

    // Byte positions inside a packet; the two checksum bytes follow the payload.
    localparam int IDX_PID     = 6;
    localparam int IDX_LEN_H   = 7;
    localparam int IDX_LEN_L   = 8;
    localparam int IDX_PAYLOAD = 9;

    function automatic logic [3:0] payload_len(input cmd_sel_e sel);
        case (sel)
            CMD_GET_IMAGE: return 4'd1;
            CMD_GEN_CHAR1: return 4'd2;
            CMD_GEN_CHAR2: return 4'd2;
            default:       return 4'd6;
        endcase
    endfunction

    function automatic logic [7:0] payload_byte(input cmd_sel_e sel, input logic [2:0] k);
        logic [7:0] v;
        v = 8'h00;
        case (sel)
            CMD_GET_IMAGE: v = GET_IMAGE;
            CMD_GEN_CHAR1: v = (k == 3'd0) ? GEN_CHAR : BUF_1;
            CMD_GEN_CHAR2: v = (k == 3'd0) ? GEN_CHAR : BUF_2;
            default: begin
                case (k)
                    3'd0:    v = SEARCH;
                    3'd1:    v = BUF_1;
                    3'd2:    v = SEARCH_START[15:8];
                    3'd3:    v = SEARCH_START[7:0];
                    3'd4:    v = SEARCH_COUNT[15:8];
                    3'd5:    v = SEARCH_COUNT[7:0];
                    default: v = 8'h00;
                endcase
            end
        endcase
        return v;
    endfunction

endpackage

// File: rtl/zhiwen_tx_byte.sv
// UART 8N1 byte serialiser. Accepts a new byte in the last cycle of the
// previous stop bit so consecutive bytes leave the line with no gap.
module zhiwen_tx_byte
    import zhiwen_pkg::*;
#(
    parameter int BIT_CYC = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic       byte_done,
    output logic       txd
);
    localparam int TMR_W = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;

    logic             r_active;
    logic [TMR_W-1:0] r_tmr;
    logic [3:0]       r_bit;
    logic [9:0]       r_shift;

    logic w_bit_end;
    logic w_last;

    assign w_bit_end  = r_active && (r_tmr == TMR_W'(BIT_CYC - 1));
    assign w_last     = w_bit_end && (r_bit == 4'd9);
    assign byte_done  = w_last;
    assign byte_ready = !r_active || w_last;
    assign txd        = r_active ? r_shift[0] : 1'b1;

    // NOTE: non-blocking assignments so every register here samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_active <= 1'b0;
            r_tmr    <= '0;
            r_bit    <= 4'd0;
            r_shift  <= '1;
        end else if (byte_valid && byte_ready) begin
            r_active <= 1'b1;
            r_tmr    <= '0;
            r_bit    <= 4'd0;
            r_shift  <= {1'b1, byte_data, 1'b0};
        end else if (w_last) begin
            r_active <= 1'b0;
        end else if (r_active) begin
            if (w_bit_end) begin
                r_tmr   <= '0;
                r_bit   <= r_bit + 4'd1;
                r_shift <= {1'b1, r_shift[9:1]};
            end else begin
                r_tmr <= r_tmr + TMR_W'(1);
            end
        end
    end

endmodule

// File: rtl/zhiwen_cmd_tx.sv
// Host-side command transmitter: builds one sensor command packet on request
// and streams it through zhiwen_tx_byte, checksum accumulated on the fly.
module zhiwen_cmd_tx
    import zhiwen_pkg::*;
#(
    parameter int          CLK_FREQ = 50_000_000,
    parameter int          BAUD     = 57600,
    parameter logic [31:0] DEV_ADDR = 32'hFFFF_FFFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] cmd_sel,
    input  logic       cmd_start,
    output logic       busy,
    output logic       done,
    output logic       txd
);
    localparam int BIT_CYC = CLK_FREQ / BAUD;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SEND, ST_FINISH} state_e;

    state_e      r_state;
    state_e      w_state_next;
    cmd_sel_e    r_sel;
    logic [4:0]  r_idx;
    logic [15:0] r_chk;

    logic [3:0]  w_plen;
    logic [15:0] w_len;
    logic [4:0]  w_chk_h_idx;
    logic [4:0]  w_last_idx;
    logic [4:0]  w_load_idx;
    logic [7:0]  w_byte_data;
    logic        w_byte_valid;
    logic        w_byte_ready;
    logic        w_byte_done;
    logic        w_sum_byte;

    assign w_plen      = payload_len(r_sel);
    assign w_len       = 16'(w_plen) + 16'd2;
    assign w_chk_h_idx = 5'(IDX_PAYLOAD) + 5'(w_plen);
    assign w_last_idx  = w_chk_h_idx + 5'd1;
    // r_idx is the byte on the line; the serialiser is always fed the one after it.
    assign w_load_idx  = (r_state == ST_LOAD) ? 5'd0 : r_idx + 5'd1;
    assign w_sum_byte  = (w_load_idx >= 5'(IDX_PID)) && (w_load_idx < w_chk_h_idx);

    assign busy = (r_state != ST_IDLE);
    assign done = (r_state == ST_FINISH);

    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    always_comb begin
        w_state_next = r_state;
        w_byte_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cmd_start) w_state_next = ST_LOAD;
            end
            ST_LOAD: begin
                w_byte_valid = 1'b1;
                w_state_next = ST_SEND;
            end
            ST_SEND: begin
                if (w_byte_done) begin
                    if (r_idx == w_last_idx) w_state_next = ST_FINISH;
                    else                     w_byte_valid = 1'b1;
                end
            end
            ST_FINISH: w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_byte_data = 8'h00;
        case (w_load_idx)
            5'd0:              w_byte_data = HDR_0;
            5'd1:              w_byte_data = HDR_1;
            5'd2:              w_byte_data = DEV_ADDR[31:24];
            5'd3:              w_byte_data = DEV_ADDR[23:16];
            5'd4:              w_byte_data = DEV_ADDR[15:8];
            5'd5:              w_byte_data = DEV_ADDR[7:0];
            5'(IDX_PID):       w_byte_data = PID_CMD;
            5'(IDX_LEN_H):     w_byte_data = w_len[15:8];
            5'(IDX_LEN_L):     w_byte_data = w_len[7:0];
            default: begin
                if (w_load_idx < w_chk_h_idx)
                    w_byte_data = payload_byte(r_sel, 3'(w_load_idx - 5'(IDX_PAYLOAD)));
                else if (w_load_idx == w_chk_h_idx)
                    w_byte_data = r_chk[15:8];
                else
                    w_byte_data = r_chk[7:0];
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_sel   <= CMD_GET_IMAGE;
            r_idx   <= 5'd0;
            r_chk   <= 16'd0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_IDLE && cmd_start) r_sel <= cmd_sel_e'(cmd_sel);
            if (w_byte_valid) r_idx <= w_load_idx;
            if (r_state == ST_LOAD)
                r_chk <= 16'd0;
            else if (w_byte_valid && w_byte_ready && w_sum_byte)
                r_chk <= r_chk + 16'(w_byte_data);
        end
    end

    zhiwen_tx_byte #(
        .BIT_CYC (BIT_CYC)
    ) u_tx_byte (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (w_byte_valid),
        .byte_data  (w_byte_data),
        .byte_ready (w_byte_ready),
        .byte_done  (w_byte_done),
        .txd        (txd)
    );

endmodule

// File: tb/tb_zhiwen_cmd_tx.sv
// Self-checking bench for zhiwen_cmd_tx: two instances (default and custom
// address) driven together and compared against a packet-level model.
module tb_zhiwen_cmd_tx;
    localparam int          CLK_FREQ = 1000;
    localparam int          BAUD     = 77;
    localparam int          B        = CLK_FREQ / BAUD;
    localparam logic [31:0] ADDR_A   = 32'hFFFF_FFFF;
    localparam logic [31:0] ADDR_B   = 32'h1234_5678;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_start;
    logic [1:0] cmd_sel;
    logic       busy_a, done_a, txd_a;
    logic       busy_b, done_b, txd_b;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_a [0:31];
    logic [7:0] exp_b [0:31];
    logic [7:0] dec_a [0:31];
    logic [7:0] dec_b [0:31];
    int         nb;

    always #5 clk = ~clk;

    zhiwen_cmd_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DEV_ADDR(ADDR_A)) dut_a (
        .clk(clk), .rst(rst), .cmd_sel(cmd_sel), .cmd_start(cmd_start),
        .busy(busy_a), .done(done_a), .txd(txd_a)
    );

    zhiwen_cmd_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DEV_ADDR(ADDR_B)) dut_b (
        .clk(clk), .rst(rst), .cmd_sel(cmd_sel), .cmd_start(cmd_start),
        .busy(busy_b), .done(done_b), .txd(txd_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Packet model straight from the command table and framing rules.
    task automatic build(input int sel);
        logic [7:0]  pl[$];
        logic [15:0] len;
        int          sum;
        pl.delete();
        case (sel)
            0:       pl = '{8'h01};
            1:       pl = '{8'h02, 8'h01};
            2:       pl = '{8'h02, 8'h02};
            default: pl = '{8'h04, 8'h01, 8'h00, 8'h00, 8'h00, 8'hC8};
        endcase
        len = 16'(pl.size() + 2);
        sum = 1 + int'(len[15:8]) + int'(len[7:0]);
        foreach (pl[i]) sum += int'(pl[i]);
        sum = sum % 65536;
        nb  = 11 + pl.size();
        exp_a[0] = 8'hEF;
        exp_a[1] = 8'h01;
        for (int i = 0; i < 4; i++) begin
            exp_a[2+i] = 8'(ADDR_A >> (24 - 8*i));
            exp_b[2+i] = 8'(ADDR_B >> (24 - 8*i));
        end
        exp_a[6] = 8'h01;
        exp_a[7] = len[15:8];
        exp_a[8] = len[7:0];
        foreach (pl[i]) exp_a[9+i] = pl[i];
        exp_a[nb-2] = 8'(sum >> 8);
        exp_a[nb-1] = 8'(sum);
        for (int i = 0; i < nb; i++)
            if (i < 2 || i > 5) exp_b[i] = exp_a[i];
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int j);
        if (j == 0) return 1'b0;
        if (j == 9) return 1'b1;
        return b[j-1];
    endfunction

    task automatic run_packet(input int sel, input bit disturb);
        int   total, mism_a, mism_b, stray, k, j;
        logic ea, eb;
        build(sel);
        cmd_sel   = 2'(sel);
        cmd_start = 1'b1;
        step();
        cmd_start = 1'b0;
        check($sformatf("s%0d_busy_accept", sel), {30'd0, busy_a, busy_b}, 32'd3);
        check($sformatf("s%0d_line_idle_t1", sel), {30'd0, txd_a, txd_b}, 32'd3);
        total  = nb * 10 * B;
        mism_a = 0;
        mism_b = 0;
        stray  = 0;
        for (int o = 0; o < total; o++) begin
            step();
            if (disturb) begin
                cmd_sel   = 2'($urandom);
                cmd_start = ($urandom_range(0, 15) == 0);
            end
            k  = o / (10 * B);
            j  = (o / B) % 10;
            ea = exp_bit(exp_a[k], j);
            eb = exp_bit(exp_b[k], j);
            if (txd_a !== ea) mism_a++;
            if (txd_b !== eb) mism_b++;
            if ({busy_a, busy_b, done_a, done_b} !== 4'b1100) stray++;
            if ((o % B) == B / 2 && j >= 1 && j <= 8) begin
                dec_a[k][j-1] = txd_a;
                dec_b[k][j-1] = txd_b;
            end
            if (o == 0) check($sformatf("s%0d_start_bit", sel), {30'd0, txd_a, txd_b}, 32'd0);
        end
        cmd_start = 1'b0;
        step();
        check($sformatf("s%0d_done_pulse", sel), {28'd0, busy_a, busy_b, done_a, done_b}, 32'hF);
        cmd_start = 1'b1;
        step();
        cmd_start = 1'b0;
        check($sformatf("s%0d_after_done", sel), {28'd0, busy_a, busy_b, done_a, done_b}, 32'h0);
        step();
        check($sformatf("s%0d_start_at_done_ignored", sel), {30'd0, busy_a, busy_b}, 32'd0);
        for (int i = 0; i < nb; i++) begin
            check($sformatf("s%0d_a_byte%0d", sel, i), {24'd0, dec_a[i]}, {24'd0, exp_a[i]});
            check($sformatf("s%0d_b_byte%0d", sel, i), {24'd0, dec_b[i]}, {24'd0, exp_b[i]});
        end
        check($sformatf("s%0d_a_wave_errs", sel), mism_a, 0);
        check($sformatf("s%0d_b_wave_errs", sel), mism_b, 0);
        check($sformatf("s%0d_busy_done_errs", sel), stray, 0);
    endtask

    task automatic run_reset_abort(input int sel);
        int bad;
        build(sel);
        cmd_sel   = 2'(sel);
        cmd_start = 1'b1;
        step();
        cmd_start = 1'b0;
        for (int o = 0; o < 5 * 10 * B + 3 * B + 5; o++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_outputs", {26'd0, txd_a, busy_a, done_a, txd_b, busy_b, done_b}, 32'h24);
        bad = 0;
        for (int o = 0; o < 30 * B; o++) begin
            step();
            if ({txd_a, busy_a, done_a, txd_b, busy_b, done_b} !== 6'b100100) bad++;
        end
        check("abort_quiet", bad, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        cmd_start = 1'b0;
        cmd_sel   = 2'd0;
        repeat (3) step();
        check("reset_outputs", {26'd0, txd_a, busy_a, done_a, txd_b, busy_b, done_b}, 32'h24);
        rst = 1'b0;
        step();
        check("idle_after_reset", {26'd0, txd_a, busy_a, done_a, txd_b, busy_b, done_b}, 32'h24);

        run_packet(0, 1'b0);
        run_packet(3, 1'b0);
        run_packet(1, 1'b0);
        run_packet(2, 1'b0);
        run_packet(3, 1'b1);
        run_packet(0, 1'b1);
        run_reset_abort(3);
        run_packet(0, 1'b0);
        for (int i = 0; i < 6; i++)
            run_packet(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
